branch_resolve_unit: RTL

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_resolve_unit.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: evaluates a conditional branch, computes target and
// redirect PC, and holds the result in a one-entry output register with statistics counters.
module branch_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   rs1_i,
    input  logic [XLEN-1:0]   rs2_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic              pred_taken_i,
    input  logic              flush_i,
    input  logic              cnt_clr_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              taken_o,
    output logic              mispredict_o,
    output logic              illegal_o,
    output logic [XLEN-1:0]   target_o,
    output logic [XLEN-1:0]   redirect_pc_o,
    output logic [CNT_W-1:0]  taken_cnt_o,
    output logic [CNT_W-1:0]  mispred_cnt_o
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              taken_q, taken_d;
    logic              mispred_q, mispred_d;
    logic              illegal_q, illegal_d;
    logic [XLEN-1:0]   target_q, target_d;
    logic [XLEN-1:0]   redirect_q, redirect_d;
    logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0]  mispred_cnt_q, mispred_cnt_d;

    logic              accept_s;
    logic              out_hs_s;
    logic              cond_s;
    logic              illegal_s;
    logic [XLEN-1:0]   target_s;
    logic [XLEN-1:0]   seq_pc_s;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]  PC_STEP = {{(XLEN-3){1'b0}}, 3'd4};

    // Ready depends only on the held state and the consumer, never on in_valid_i.
    always_comb begin
        in_ready_o = (state_q == EMPTY) || out_ready_i;
        accept_s   = in_valid_i && in_ready_o && !flush_i;
        out_hs_s   = (state_q == FULL) && out_ready_i;
    end

    // Branch condition decode; codes 010/011 are reserved and never taken.
    always_comb begin
        cond_s    = 1'b0;
        illegal_s = 1'b0;
        case (funct3_i)
            3'b000:  cond_s = (rs1_i == rs2_i);
            3'b001:  cond_s = (rs1_i != rs2_i);
            3'b100:  cond_s = ($signed(rs1_i) <  $signed(rs2_i));
            3'b101:  cond_s = ($signed(rs1_i) >= $signed(rs2_i));
            3'b110:  cond_s = (rs1_i <  rs2_i);
            3'b111:  cond_s = (rs1_i >= rs2_i);
            default: illegal_s = 1'b1;
        endcase
        target_s = pc_i + imm_i;
        seq_pc_s = pc_i + PC_STEP;
    end

    // Output register next-state: flush empties, accept loads, handshake drains.
    always_comb begin
        state_d    = state_q;
        taken_d    = taken_q;
        mispred_d  = mispred_q;
        illegal_d  = illegal_q;
        target_d   = target_q;
        redirect_d = redirect_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else if (accept_s) begin
            state_d    = FULL;
            taken_d    = cond_s;
            mispred_d  = cond_s ^ pred_taken_i;
            illegal_d  = illegal_s;
            target_d   = target_s;
            redirect_d = cond_s ? target_s : seq_pc_s;
        end else if (out_hs_s) begin
            state_d = EMPTY;
        end else begin
            state_d = state_q;
        end
    end

    // Saturating statistics; clear wins over a same-cycle increment.
    always_comb begin
        taken_cnt_d   = taken_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (cnt_clr_i) begin
            taken_cnt_d   = {CNT_W{1'b0}};
            mispred_cnt_d = {CNT_W{1'b0}};
        end else if (out_hs_s) begin
            if (taken_q && (taken_cnt_q != CNT_MAX)) begin
                taken_cnt_d = taken_cnt_q + CNT_ONE;
            end else begin
                taken_cnt_d = taken_cnt_q;
            end
            if (mispred_q && (mispred_cnt_q != CNT_MAX)) begin
                mispred_cnt_d = mispred_cnt_q + CNT_ONE;
            end else begin
                mispred_cnt_d = mispred_cnt_q;
            end
        end else begin
            taken_cnt_d   = taken_cnt_q;
            mispred_cnt_d = mispred_cnt_q;
        end
    end

    // State, result and counter registers; reset clears everything immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= EMPTY;
            taken_q       <= 1'b0;
            mispred_q     <= 1'b0;
            illegal_q     <= 1'b0;
            target_q      <= {XLEN{1'b0}};
            redirect_q    <= {XLEN{1'b0}};
            taken_cnt_q   <= {CNT_W{1'b0}};
            mispred_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            taken_q       <= taken_d;
            mispred_q     <= mispred_d;
            illegal_q     <= illegal_d;
            target_q      <= target_d;
            redirect_q    <= redirect_d;
            taken_cnt_q   <= taken_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign out_valid_o   = (state_q == FULL);
    assign taken_o       = taken_q;
    assign mispredict_o  = mispred_q;
    assign illegal_o     = illegal_q;
    assign target_o      = target_q;
    assign redirect_pc_o = redirect_q;
    assign taken_cnt_o   = taken_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule
